// File: rtl/pipe_pkg.sv
// Shared types for the generic pipeline stage buffer: occupancy states and the
// MEM/WB payload bundle.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned PC_W       = 32;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned WDSEL_W    = 3;

    typedef struct packed {
        logic [INSTR_W-1:0]    instr;
        logic [PC_W-1:0]       pc;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       dm_data;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic [WDSEL_W-1:0]    wd_sel;
    } wb_payload_t;

    localparam int unsigned WB_PAYLOAD_W = $bits(wb_payload_t);

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module pipe_sat_cnt
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer and registered in_ready_o.
// Optional stall/flush performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W         = WB_PAYLOAD_W,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
`ifdef PIPE_STAGE_PERF_EN
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`else
    output logic [DATA_W-1:0] out_data_o
`endif
);

    pipe_state_e       r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic              w_acc;
    logic              w_pop;

    // Ready and valid decode from the state register only; no input reaches them.
    assign in_ready_o  = (r_state != FULL);
    assign out_valid_o = (r_state != EMPTY);
    assign out_data_o  = r_main;

    assign w_acc = in_valid_i & in_ready_o;
    assign w_pop = out_valid_o & out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush_i) begin
            r_state <= EMPTY;
            if (CLEAR_ON_FLUSH) begin
                r_main <= '0;
                r_skid <= '0;
            end
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        r_state <= ONE;
                        r_main  <= in_data_i;
                    end
                end
                ONE: begin
                    if (w_acc && w_pop) begin
                        r_main <= in_data_i;
                    end else if (w_acc) begin
                        r_state <= FULL;
                        r_skid  <= in_data_i;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    // Skid entry is younger; it moves up only once main is consumed.
                    if (w_pop) begin
                        r_state <= ONE;
                        r_main  <= r_skid;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic w_stall_inc;
    logic w_flush_inc;

    assign w_stall_inc = out_valid_o & ~out_ready_i;
    // Main is always valid whenever any entry is held.
    assign w_flush_inc = flush_i & out_valid_o;

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_stall_inc),
        .i_clr (1'b0),
        .o_cnt (stall_cnt_o)
    );

    pipe_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_flush_inc),
        .i_clr (1'b0),
        .o_cnt (flush_cnt_o)
    );
`else
    // CNT_W only sizes the optional counter ports.
    if (CNT_W == 0) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench: a 2-deep FIFO reference model predicts every handshake and payload.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int unsigned DW      = WB_PAYLOAD_W;
    localparam int unsigned CW      = 4;
    localparam int          SAT_MAX = (1 << CW) - 1;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic          in_ready, out_valid, in_ready_nc, out_valid_nc;
    logic [DW-1:0] out_data, out_data_nc;
`ifdef PIPE_STAGE_PERF_EN
    logic [CW-1:0] stall_cnt, flush_cnt, stall_cnt_nc, flush_cnt_nc;
`endif

    pipe_stage_buf #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
`ifdef PIPE_STAGE_PERF_EN
        .out_data_o  (out_data),
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt)
`else
        .out_data_o  (out_data)
`endif
    );

    pipe_stage_buf #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b0), .CNT_W(CW)) dut_nc (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_nc),
        .in_data_i   (in_data),
        .out_valid_o (out_valid_nc),
        .out_ready_i (out_ready),
`ifdef PIPE_STAGE_PERF_EN
        .out_data_o  (out_data_nc),
        .stall_cnt_o (stall_cnt_nc),
        .flush_cnt_o (flush_cnt_nc)
`else
        .out_data_o  (out_data_nc)
`endif
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] exp_q[$];
    bit            exp_zero = 1'b1;
    int            stall_m  = 0;
    int            flush_m  = 0;

    function automatic void chkd(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void chk1(string name, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endfunction

    function automatic void chkn(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: samples 1 ns before each rising edge, compares, then advances the model.
    initial begin : monitor
        bit ready_m;
        bit valid_m;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                exp_q.delete();
                exp_zero = 1'b1;
                stall_m  = 0;
                flush_m  = 0;
            end
            ready_m = (exp_q.size() < 2);
            valid_m = (exp_q.size() != 0);
            chk1("in_ready", in_ready, ready_m);
            chk1("out_valid", out_valid, valid_m);
            chk1("in_ready_nc", in_ready_nc, ready_m);
            chk1("out_valid_nc", out_valid_nc, valid_m);
            if (valid_m) begin
                chkd("out_data", out_data, exp_q[0]);
                chkd("out_data_nc", out_data_nc, exp_q[0]);
            end else if (exp_zero) begin
                chkd("out_data_cleared", out_data, '0);
            end
`ifdef PIPE_STAGE_PERF_EN
            chkn("stall_cnt", int'(stall_cnt), stall_m);
            chkn("flush_cnt", int'(flush_cnt), flush_m);
            chkn("stall_cnt_nc", int'(stall_cnt_nc), stall_m);
            chkn("flush_cnt_nc", int'(flush_cnt_nc), flush_m);
`endif
            if (!rst) begin
                if (valid_m && !out_ready && stall_m < SAT_MAX) stall_m++;
                if (flush && valid_m && flush_m < SAT_MAX) flush_m++;
                if (flush) begin
                    exp_q.delete();
                    exp_zero = 1'b1;
                end else begin
                    if (valid_m && out_ready) void'(exp_q.pop_front());
                    if (in_valid && ready_m) begin
                        exp_q.push_back(in_data);
                        exp_zero = 1'b0;
                    end
                end
            end
        end
    end

    // Entered on a falling edge; returns on the falling edge after the beat is taken.
    task automatic send(input logic [DW-1:0] d);
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            #4;
            acc = in_ready && !flush && !rst;
            @(negedge clk);
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: beat 0x%0h not accepted within 50 cycles", d);
    endtask

    initial begin : stimulus
        @(negedge clk);
        #1;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b1);
        chkd("reset_out_data", out_data, '0);
        @(negedge clk);
        rst = 1'b0;

        // Streaming at full throughput.
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) send(DW'(i));
        repeat (3) @(negedge clk);

        // Back-pressure: fill main and skid, offer a third beat.
        out_ready = 1'b0;
        send(DW'(32'h11));
        send(DW'(32'h22));
        in_valid = 1'b1;
        in_data  = DW'(32'h33);
        repeat (3) @(negedge clk);
        #4;
        chk1("full_in_ready", in_ready, 1'b0);
        chkd("full_head_stable", out_data, DW'(32'h11));
        @(negedge clk);
        out_ready = 1'b1;
        send(DW'(32'h33));
        repeat (4) @(negedge clk);

        // Asynchronous reset with two entries held.
        out_ready = 1'b0;
        send(DW'(32'h5a));
        send(DW'(32'h5b));
        #2;
        rst = 1'b1;
        #1;
        chk1("async_rst_out_valid", out_valid, 1'b0);
        chk1("async_rst_in_ready", in_ready, 1'b1);
        chkd("async_rst_out_data", out_data, '0);
        chk1("async_rst_out_valid_nc", out_valid_nc, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send(DW'(32'h55));
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Flush from FULL beats a simultaneous accept and pop.
        out_ready = 1'b0;
        send(DW'(32'h66));
        send(DW'(32'h77));
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'(32'h44);
        out_ready = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #4;
        chk1("flush_out_valid", out_valid, 1'b0);
        chkd("flush_out_data", out_data, '0);
        chk1("flush_in_ready", in_ready, 1'b1);
        chk1("flush_out_valid_nc", out_valid_nc, 1'b0);
        @(negedge clk);
        repeat (3) @(negedge clk);

        // Randomised traffic with occasional flushes.
        for (int c = 0; c < 800; c++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = 1'($urandom_range(0, 19) == 0);
            for (int k = 0; k < int'(DW); k++) in_data[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

`ifdef PIPE_STAGE_PERF_EN
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b0;
        send(DW'(32'h1));
        repeat (20) @(negedge clk);
        #4;
        chkn("stall_saturated", int'(stall_cnt), SAT_MAX);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            send(DW'(j + 2));
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        #4;
        chkn("flush_count", int'(flush_cnt), 3);
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
